// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - request, register-file, ALU and writeback bus of the ALU issue controller
interface alu_issue_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) ();
  // decode-side request
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [AW-1:0]    req_rd;
  logic [AW-1:0]    req_rs;
  logic [AW-1:0]    req_rt;
  logic             req_imm_sel;
  logic [WIDTH-1:0] req_imm;
  // register-file read port
  logic             rf_re;
  logic [AW-1:0]    rf_ra0;
  logic [AW-1:0]    rf_ra1;
  logic [WIDTH-1:0] rf_rd0;
  logic [WIDTH-1:0] rf_rd1;
  // ALU
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_r;
  logic             alu_zero;
  logic             alu_ovfl;
  // register-file write port
  logic             wb_valid;
  logic             wb_ready;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;
  // status
  logic             flag_z;
  logic             flag_v;
  logic             busy;

  // controller side
  modport master (
    input  req_valid, req_op, req_rd, req_rs, req_rt, req_imm_sel, req_imm,
    input  rf_rd0, rf_rd1, alu_r, alu_zero, alu_ovfl, wb_ready,
    output req_ready, rf_re, rf_ra0, rf_ra1, alu_a, alu_b, alu_op,
    output wb_valid, wb_addr, wb_data, flag_z, flag_v, busy
  );

  // decode / register file / ALU side
  modport slave (
    output req_valid, req_op, req_rd, req_rs, req_rt, req_imm_sel, req_imm,
    output rf_rd0, rf_rd1, alu_r, alu_zero, alu_ovfl, wb_ready,
    input  req_ready, rf_re, rf_ra0, rf_ra1, alu_a, alu_b, alu_op,
    input  wb_valid, wb_addr, wb_data, flag_z, flag_v, busy
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - multi-cycle issue/writeback controller driving a combinational ALU
module alu_issue_ctrl #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_OPND = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_req_ready;
  logic             w_rf_re;
  logic             w_wb_valid;
  logic             w_accept;

  logic [2:0]       r_op;
  logic [AW-1:0]    r_rd;
  logic             r_imm_sel;
  logic [WIDTH-1:0] r_imm;
  logic [AW-1:0]    r_ra0;
  logic [AW-1:0]    r_ra1;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [2:0]       r_alu_op;
  logic [AW-1:0]    r_wb_addr;
  logic [WIDTH-1:0] r_wb_data;
  logic             r_flag_z;
  logic             r_flag_v;

  // State register; reset aborts any in-flight instruction immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-state strobes; req_ready depends on state only
  always_comb begin
    w_next      = r_state;
    w_req_ready = 1'b0;
    w_rf_re     = 1'b0;
    w_wb_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
          w_next = S_READ;
        end
      end
      S_READ: begin
        w_rf_re = 1'b1;
        w_next  = S_OPND;
      end
      S_OPND: begin
        w_next = S_EXEC;
      end
      S_EXEC: begin
        // register 0 is never written, so skip the writeback entirely
        w_next = (r_rd == '0) ? S_IDLE : S_WB;
      end
      S_WB: begin
        w_wb_valid = 1'b1;
        if (bus.wb_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign w_accept = w_req_ready & bus.req_valid;

  // Capture the request; read addresses are presented from READ onward and then held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= '0;
      r_rd      <= '0;
      r_imm_sel <= 1'b0;
      r_imm     <= '0;
      r_ra0     <= '0;
      r_ra1     <= '0;
    end else if (w_accept) begin
      r_op      <= bus.req_op;
      r_rd      <= bus.req_rd;
      r_imm_sel <= bus.req_imm_sel;
      r_imm     <= bus.req_imm;
      r_ra0     <= bus.req_rs;
      r_ra1     <= bus.req_rt;
    end
  end

  // Load ALU operands in OPND; they stay put until the next instruction's OPND
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
    end else if (r_state == S_OPND) begin
      r_alu_a  <= bus.rf_rd0;
      r_alu_b  <= r_imm_sel ? r_imm : bus.rf_rd1;
      r_alu_op <= r_op;
    end
  end

  // Capture result and flags in EXEC; wb_addr only moves when a writeback will follow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_data <= '0;
      r_wb_addr <= '0;
      r_flag_z  <= 1'b0;
      r_flag_v  <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_wb_data <= bus.alu_r;
      r_flag_z  <= bus.alu_zero;
      r_flag_v  <= bus.alu_ovfl;
      if (r_rd != '0) begin
        r_wb_addr <= r_rd;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rf_re     = w_rf_re;
  assign bus.rf_ra0    = r_ra0;
  assign bus.rf_ra1    = r_ra1;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_op    = r_alu_op;
  assign bus.wb_valid  = w_wb_valid;
  assign bus.wb_addr   = r_wb_addr;
  assign bus.wb_data   = r_wb_data;
  assign bus.flag_z    = r_flag_z;
  assign bus.flag_v    = r_flag_v;
  assign bus.busy      = (r_state != S_IDLE);

endmodule
